pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

- Supervises the video/system PLL from the reference-clock side.
- Drives the PLL reset, synchronises and filters the asynchronous PLL `locked` flag, and releases a single active-high core reset only after lock has been stable and a hold-off interval has elapsed.
- Detects loss of lock during run, re-arms the PLL and counts such events.
- Sits between the 50 MHz board clock input and the core reset tree.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser flops on `pll_locked` (≥2).
- `RST_PULSE`, 16: cycles `pll_rst` is held high per PLL reset.
- `FILTER_CYCLES`, 1024: consecutive synced-high samples required to accept lock.
- `HOLD_CYCLES`, 4096: cycles `sys_reset` stays high after lock is accepted.
- `TIMEOUT_CYCLES`, 1048576: cycles allowed in WAIT_LOCK before a retry (macro only).
- `CNT_W`, 8: width of `loss_count`.

Ports:
- `clock` in 1: 50 MHz reference clock; the same clock that feeds the PLL `refclk`.
- `reset` in 1: synchronous, active-high.
- `pll_locked` in 1: PLL lock flag; asynchronous to `clock`.
- `clear_count` in 1: synchronous clear of `loss_count`.
- `pll_rst` out 1: PLL reset, active-high.
- `sys_reset` out 1: core reset, active-high.
- `ready` out 1: high while the clocks are valid.
- `lock_lost` out 1: one-cycle pulse on each loss of lock in RUN.
- `loss_count` out CNT_W: saturating count of losses of lock in RUN.

## Operation
- `pll_locked` passes through `SYNC_STAGES` flops to give `lk`. All decisions use `lk` only.
- FSM states: PLL_RST, WAIT_LOCK, HOLD, RUN. A single shared cycle counter `cnt` clears on every state change.
- **PLL_RST**
  - `pll_rst`=1.
  - At `cnt`==RST_PULSE-1, go to WAIT_LOCK.
  - `lk` is ignored.
- **WAIT_LOCK**
  - While `lk`=1, `cnt` increments. When `lk`=0, `cnt` clears (glitch filter).
  - When `lk`=1 and `cnt`==FILTER_CYCLES-1, go to HOLD.
- **HOLD**
  - `cnt` increments each cycle.
  - If `lk`=0, go to PLL_RST. There is no count or pulse in this case.
  - At `cnt`==HOLD_CYCLES-1 with `lk`=1, go to RUN.
- **RUN**
  - `lk`=0 causes a transition to PLL_RST, together with:
    - `lock_lost` pulses for one cycle;
    - `loss_count` increments, saturating at all-ones.
- Outputs are Moore decodes of the registered state:
  - `pll_rst` = (state==PLL_RST).
  - `sys_reset` = (state!=RUN).
  - `ready` = (state==RUN).
- `lock_lost` is registered. It is high in the first PLL_RST cycle after leaving RUN.
- `clear_count`:
  - Sets `loss_count` to 0.
  - If `clear_count` and a loss occur in the same cycle, `loss_count` becomes 1.
- Counter widths are sized by `$clog2` of the largest parameter. Comparisons are exact, with no wrap inside a state.

## Timing
- Reset values, applied the cycle after `reset`:
  - state=PLL_RST, `cnt`=0, synchroniser flops=0.
  - `pll_rst`=1, `sys_reset`=1, `ready`=0, `lock_lost`=0, `loss_count`=0.
- Asserting `reset` mid-operation, in any state, restores these values on the next edge.
- Input latency: a raw `pll_locked` edge reaches `lk` after SYNC_STAGES cycles.
- Let T be the first cycle with `lk`=1 in WAIT_LOCK, and assume `lk` stays high:
  - HOLD is entered at T+FILTER_CYCLES.
  - RUN is entered, with `sys_reset`=0 and `ready`=1, at T+FILTER_CYCLES+HOLD_CYCLES.
- Loss in RUN: `lk`=0 at cycle L gives `sys_reset`=1, `ready`=0, `pll_rst`=1 and `lock_lost`=1 at L+1.
- `loss_count` updates at L+1.
- A full PLL_RST pulse is exactly RST_PULSE cycles.

## Configuration
- `PLL_SUP_RETRY_EN` defined:
  - In WAIT_LOCK, a second counter `tmo` counts every cycle. It does not reset on `lk` glitches and clears on state entry.
  - At `tmo`==TIMEOUT_CYCLES-1 without reaching HOLD, the FSM goes to PLL_RST and the PLL is re-reset.
- `PLL_SUP_RETRY_EN` undefined:
  - No `tmo` logic is present.
  - WAIT_LOCK waits indefinitely.
  - `pll_rst` pulses only after reset or a loss of lock.

## Test plan
Bench parameters: SYNC_STAGES=2, RST_PULSE=4, FILTER_CYCLES=8, HOLD_CYCLES=16, TIMEOUT_CYCLES=64, CNT_W=2.

1. **Reset with no lock.** Release `reset` with `pll_locked`=0, macro off → `pll_rst` high for exactly 4 cycles then low forever; `sys_reset`=1 and `ready`=0 throughout.
2. **Clean lock.** `pll_locked` rises at raw cycle R (`lk` rises at R+2) → HOLD at R+10; `sys_reset` falls and `ready` rises at R+26; `pll_rst` stays 0.
3. **Glitch during filter.** `pll_locked` drops for 1 cycle on the 6th synced-high sample → filter restarts; HOLD is entered 8 cycles after the recovered `lk` high.
4. **Loss in RUN.** `pll_locked` drops in RUN (`lk`=0 at L) → at L+1: `lock_lost`=1 for one cycle, `loss_count` 0→1, `sys_reset`=1, `pll_rst` high for cycles L+1..L+4.
5. **Saturation and clear.**
   - Four losses in RUN → `loss_count`=3 and held.
   - `clear_count` pulsed in the same cycle as a fifth loss → `loss_count`=1.
6. **Retry (macro on).** `pll_locked` held 0 → `pll_rst` pulses of 4 cycles repeat every 68 cycles. Toggling `pll_locked` every 3 cycles still triggers the timeout.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Supervises a PLL from the reference-clock side. It drives the PLL reset,
// synchronises and filters the asynchronous PLL lock flag, and holds the core
// reset until lock has been stable for FILTER_CYCLES and a further HOLD_CYCLES
// have elapsed. A loss of lock while running re-arms the PLL, emits a
// one-cycle lock_lost_o pulse and bumps a saturating loss counter.
//
// Optional feature macro: PLL_SUP_RETRY_EN
//   When defined, WAIT_LOCK is bounded by TIMEOUT_CYCLES. On expiry the PLL is
//   reset again. When undefined, WAIT_LOCK waits indefinitely.
//
// Ports
//   clock_i        : reference clock (also feeds the PLL refclk)
//   reset_i        : synchronous, active-high reset
//   pll_locked_i   : PLL lock flag, asynchronous to clock_i
//   clear_count_i  : synchronous clear of loss_count_o
//   pll_rst_o      : PLL reset, active-high
//   sys_reset_o    : core reset, active-high
//   ready_o        : high while the PLL clocks are valid
//   lock_lost_o    : one-cycle pulse on each loss of lock while running
//   loss_count_o   : saturating count of losses of lock while running
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int RST_PULSE      = 16,
    parameter int FILTER_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 4096,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             pll_locked_i,
    input  logic             clear_count_i,
    output logic             pll_rst_o,
    output logic             sys_reset_o,
    output logic             ready_o,
    output logic             lock_lost_o,
    output logic [CNT_W-1:0] loss_count_o
);

    // Counters are sized from the largest interval parameter so that every
    // terminal value fits exactly and no count wraps inside a state.
    localparam int MAX_A  = (RST_PULSE > FILTER_CYCLES) ? RST_PULSE : FILTER_CYCLES;
    localparam int MAX_B  = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(FILTER_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk_s;
    logic                   loss_s;
    logic                   timeout_s;
    logic                   lock_lost_q;
    logic [CNT_W-1:0]       loss_count_q;

    // Saturating increment of the loss counter: stops at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Synchroniser chain for the asynchronous lock flag; lk_s is its last flop.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
        end
    end

    assign lk_s = sync_q[SYNC_STAGES-1];

`ifdef PLL_SUP_RETRY_EN
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] tmo_q;
    logic [CW-1:0] tmo_d;

    // Timeout counter: runs every WAIT_LOCK cycle, ignores lk glitches and
    // restarts from zero whenever WAIT_LOCK is (re)entered.
    always_comb begin
        if ((state_q == ST_WAIT_LOCK) && (state_d == ST_WAIT_LOCK)) begin
            tmo_d = tmo_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            tmo_d = {CW{1'b0}};
        end
    end

    // Timeout counter register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            tmo_q <= {CW{1'b0}};
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign timeout_s = (tmo_q == TMO_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // FSM state register and the shared phase counter.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_PLL_RST;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state logic; the shared counter restarts on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        loss_s  = 1'b0;
        case (state_q)
            ST_PLL_RST: begin
                // lk is deliberately ignored while the PLL is held in reset.
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    state_d = ST_PLL_RST;
                end
            end
            ST_WAIT_LOCK: begin
                // Glitch filter: any low sample restarts the stable-lock count.
                if (lk_s && (cnt_q == FILT_LAST)) begin
                    state_d = ST_HOLD;
                end else if (timeout_s) begin
                    state_d = ST_PLL_RST;
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
                if (!lk_s) begin
                    cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_HOLD: begin
                // Losing lock before the core is released is silent: no count.
                if (!lk_s) begin
                    state_d = ST_PLL_RST;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q;
                if (!lk_s) begin
                    state_d = ST_PLL_RST;
                    loss_s  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_d;
        end
    end

    // Moore output decode of the registered state.
    always_comb begin
        pll_rst_o   = 1'b0;
        sys_reset_o = 1'b1;
        ready_o     = 1'b0;
        case (state_q)
            ST_PLL_RST: begin
                pll_rst_o = 1'b1;
            end
            ST_RUN: begin
                sys_reset_o = 1'b0;
                ready_o     = 1'b1;
            end
            default: begin
                pll_rst_o   = 1'b0;
                sys_reset_o = 1'b1;
                ready_o     = 1'b0;
            end
        endcase
    end

    // Loss-of-lock pulse and saturating loss counter; a loss coinciding with a
    // clear leaves exactly that one loss recorded.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            lock_lost_q  <= 1'b0;
            loss_count_q <= {CNT_W{1'b0}};
        end else begin
            lock_lost_q <= loss_s;
            if (clear_count_i) begin
                loss_count_q <= loss_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
            end else if (loss_s) begin
                loss_count_q <= sat_inc(loss_count_q);
            end else begin
                loss_count_q <= loss_count_q;
            end
        end
    end

    assign lock_lost_o  = lock_lost_q;
    assign loss_count_o = loss_count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pll_lock_supervisor.
// A timestamp-based reference model (phase entry times, last low lk sample,
// a queue for the synchroniser delay) predicts the outputs every cycle, and
// directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int SYNC    = 2;
    localparam int RSTP    = 4;
    localparam int FILT    = 8;
    localparam int HOLDC   = 16;
    localparam int TMO     = 64;
    localparam int CW      = 2;
    localparam int CNT_MAX = 3;

    logic          clk;
    logic          reset_s;
    logic          locked_s;
    logic          clr_s;
    logic          pll_rst;
    logic          sys_reset;
    logic          ready;
    logic          lock_lost;
    logic [CW-1:0] loss_count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int m_n       = 0;   // index of the current cycle
    int m_ph      = 0;   // 0 PLL reset, 1 waiting, 2 holding, 3 running
    int m_start   = 0;   // first cycle of current phase
    int m_lastlow = 0;   // last cycle with lk low
    bit m_lost    = 1'b0;
    int m_cnt     = 0;
    bit m_q[$];

    pll_lock_supervisor #(
        .SYNC_STAGES    (SYNC),
        .RST_PULSE      (RSTP),
        .FILTER_CYCLES  (FILT),
        .HOLD_CYCLES    (HOLDC),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CW)
    ) dut (
        .clock_i       (clk),
        .reset_i       (reset_s),
        .pll_locked_i  (locked_s),
        .clear_count_i (clr_s),
        .pll_rst_o     (pll_rst),
        .sys_reset_o   (sys_reset),
        .ready_o       (ready),
        .lock_lost_o   (lock_lost),
        .loss_count_o  (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_edge();
        bit lk;
        int nph;
        int el;
        int rs;
        bit lost;
        lk = (m_q.size() > 0) ? m_q[0] : 1'b0;
        if (reset_s) begin
            m_ph      = 0;
            m_start   = m_n + 1;
            m_lastlow = m_n;
            m_lost    = 1'b0;
            m_cnt     = 0;
            m_q.delete();
            for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
        end else begin
            el   = m_n - m_start;
            nph  = m_ph;
            lost = 1'b0;
            case (m_ph)
                0: if (el == RSTP - 1) nph = 1;
                1: begin
                    if (lk) begin
                        rs = (m_lastlow + 1 > m_start) ? m_lastlow + 1 : m_start;
                        if (m_n - rs + 1 == FILT) nph = 2;
                    end
`ifdef PLL_SUP_RETRY_EN
                    if (nph == 1 && el + 1 == TMO) nph = 0;
`endif
                end
                2: if (!lk) nph = 0; else if (el + 1 == HOLDC) nph = 3;
                3: if (!lk) begin nph = 0; lost = 1'b1; end
                default: nph = 0;
            endcase
            if (!lk) m_lastlow = m_n;
            if (nph != m_ph) begin
                m_ph    = nph;
                m_start = m_n + 1;
            end
            m_lost = lost;
            if (clr_s) m_cnt = lost ? 1 : 0;
            else if (lost && m_cnt < CNT_MAX) m_cnt++;
            void'(m_q.pop_front());
            m_q.push_back(locked_s);
        end
        m_n++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pll_rst",    {31'd0, pll_rst},    (m_ph == 0) ? 32'd1 : 32'd0);
            chk("model_sys_reset",  {31'd0, sys_reset},  (m_ph != 3) ? 32'd1 : 32'd0);
            chk("model_ready",      {31'd0, ready},      (m_ph == 3) ? 32'd1 : 32'd0);
            chk("model_lock_lost",  {31'd0, lock_lost},  {31'd0, m_lost});
            chk("model_loss_count", {30'd0, loss_count}, m_cnt);
        end
    end

    int ones;

    initial begin
        reset_s  = 1'b1;
        locked_s = 1'b0;
        clr_s    = 1'b0;
        @(negedge clk);
        step();
        step();
        chk_en = 1'b1;
        // Reset values
        chk("rst_pll_rst",    {31'd0, pll_rst},    32'd1);
        chk("rst_sys_reset",  {31'd0, sys_reset},  32'd1);
        chk("rst_ready",      {31'd0, ready},      32'd0);
        chk("rst_lock_lost",  {31'd0, lock_lost},  32'd0);
        chk("rst_loss_count", {30'd0, loss_count}, 32'd0);

        // 1: reset release with no lock: exactly RSTP cycles of pll_rst
        reset_s = 1'b0;
        ones = pll_rst ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pll_rst) ones++;
        end
        chk("t1_pll_rst_cycles", ones, 32'd4);
        chk("t1_pll_rst_low", {31'd0, pll_rst}, 32'd0);

        // 2: clean lock, RUN entered 26 cycles after the raw rise
        locked_s = 1'b1;
        repeat (25) step();
        chk("t2_ready_before", {31'd0, ready}, 32'd0);
        step();
        chk("t2_ready_at_26", {31'd0, ready}, 32'd1);
        chk("t2_sys_reset_at_26", {31'd0, sys_reset}, 32'd0);
        repeat (5) step();

        // 4: loss in RUN; lk low at D+2, effects at D+3
        locked_s = 1'b0;
        repeat (2) step();
        chk("t4_ready_at_L", {31'd0, ready}, 32'd1);
        step();
        chk("t4_lock_lost", {31'd0, lock_lost}, 32'd1);
        chk("t4_loss_count", {30'd0, loss_count}, 32'd1);
        chk("t4_pll_rst_first", {31'd0, pll_rst}, 32'd1);
        step();
        chk("t4_lock_lost_1cyc", {31'd0, lock_lost}, 32'd0);
        repeat (2) step();
        chk("t4_pll_rst_last", {31'd0, pll_rst}, 32'd1);
        step();
        chk("t4_pll_rst_end", {31'd0, pll_rst}, 32'd0);
        repeat (3) step();

        // 3: one-cycle glitch on the 6th synced-high sample restarts the filter
        locked_s = 1'b1;
        repeat (5) step();
        locked_s = 1'b0;
        step();
        locked_s = 1'b1;
        repeat (25) step();
        chk("t3_ready_before", {31'd0, ready}, 32'd0);
        step();
        chk("t3_ready_at_32", {31'd0, ready}, 32'd1);
        repeat (3) step();

        // 5: clear, then four losses saturate at 3
        clr_s = 1'b1;
        step();
        clr_s = 1'b0;
        chk("t5_cleared", {30'd0, loss_count}, 32'd0);
        locked_s = 1'b0;
        repeat (10) step();
        for (int i = 0; i < 3; i++) begin
            locked_s = 1'b1;
            repeat (40) step();
            locked_s = 1'b0;
            repeat (10) step();
        end
        chk("t5_saturated", {30'd0, loss_count}, 32'd3);
        // Fifth loss with clear in the same cycle
        locked_s = 1'b1;
        repeat (40) step();
        locked_s = 1'b0;
        repeat (2) step();
        clr_s = 1'b1;
        step();
        clr_s = 1'b0;
        chk("t5_clear_and_loss", {30'd0, loss_count}, 32'd1);
        chk("t5_lock_lost", {31'd0, lock_lost}, 32'd1);
        repeat (10) step();

        // Mid-operation reset from RUN
        locked_s = 1'b1;
        repeat (40) step();
        chk("mr_ready_before", {31'd0, ready}, 32'd1);
        reset_s = 1'b1;
        step();
        reset_s  = 1'b0;
        locked_s = 1'b0;
        chk("mr_pll_rst",    {31'd0, pll_rst},    32'd1);
        chk("mr_ready",      {31'd0, ready},      32'd0);
        chk("mr_loss_count", {30'd0, loss_count}, 32'd0);
        repeat (10) step();

`ifdef PLL_SUP_RETRY_EN
        // 6: retry; pll_rst pulses of 4 every 68 cycles
        reset_s = 1'b1;
        step();
        reset_s = 1'b0;
        repeat (67) step();
        chk("t6_rst_low_67", {31'd0, pll_rst}, 32'd0);
        step();
        chk("t6_rst_high_68", {31'd0, pll_rst}, 32'd1);
        repeat (3) step();
        chk("t6_rst_high_71", {31'd0, pll_rst}, 32'd1);
        step();
        chk("t6_rst_low_72", {31'd0, pll_rst}, 32'd0);
        for (int k = 73; k <= 136; k++) begin
            if (k % 3 == 0) locked_s = ~locked_s;
            step();
            if (k == 135) chk("t6_toggle_low_135", {31'd0, pll_rst}, 32'd0);
            if (k == 136) chk("t6_toggle_high_136", {31'd0, pll_rst}, 32'd1);
        end
        repeat (5) step();
`endif

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
